adder16_arbiter: RTL and testbench

- Shares one 16-bit ripple adder (fulladder16, carry-in tied 0) between two requesters.
- Arbitrates requests, registers the chosen operands, and lets the adder settle for one full cycle.
- Captures sum and carry-out and returns them on a single response channel tagged with the requester ID.
- Sits between two ALU-side clients and the shared adder datapath.

---
 rtl/adder16_arbiter_if.sv | 15 +
 rtl/adder16_arbiter.sv | 74 +++++++
 tb/tb_adder16_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/adder16_arbiter_if.sv
// adder16_arbiter_if: request/response bundle between two clients and the shared adder arbiter
interface adder16_arbiter_if;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
   logic [15:0] rsp_sum;
   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );
   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );
endinterface

// File: rtl/adder16_arbiter.sv
// adder16_arbiter: shares one 16-bit ripple adder between two requesters with a tagged response
module adder16_arbiter #(
   parameter bit PRIO_FIXED = 1'b0
) (
   input logic               clk,
   input logic               rst_n,
   adder16_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;
   state_t      r_state, w_next;
   logic [15:0] r_a, r_b, r_rsp_sum, w_sum;
   logic [16:0] w_c;
   logic        r_id, r_last, r_rsp_valid, r_rsp_id, r_rsp_cout, w_grant, w_hs;
   assign w_c[0] = 1'b0;
   for (genvar i = 0; i < 16; i++) begin : g_fa
      assign w_sum[i]   = r_a[i] ^ r_b[i] ^ w_c[i];
      assign w_c[i + 1] = (r_a[i] & r_b[i]) | (w_c[i] & (r_a[i] ^ r_b[i]));
   end
   // winner: the lone requester, or on a tie requester 0 (fixed) / the one not served last (round-robin)
   always_comb begin
      w_grant = (bus.req0_valid && bus.req1_valid) ? (PRIO_FIXED ? 1'b0 : ~r_last) : !bus.req0_valid;
   end
   assign bus.req0_ready = (r_state == IDLE) && bus.req0_valid && !w_grant;
   assign bus.req1_ready = (r_state == IDLE) && bus.req1_valid && w_grant;
   assign w_hs           = bus.req0_ready || bus.req1_ready;
   // next state: accept in IDLE, one settle cycle in ADD, hold RESP until the consumer takes it
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_hs ? ADD : IDLE;
         ADD:     w_next = RESP;
         default: w_next = bus.rsp_ready ? IDLE : RESP;
      endcase
   end
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end
   // operand capture at the handshake, result capture after the settle cycle, grant history on release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_id        <= 1'b0;
         r_last      <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_sum   <= '0;
         r_rsp_cout  <= 1'b0;
      end else begin
         if (w_hs) begin
            r_a  <= w_grant ? bus.req1_a : bus.req0_a;
            r_b  <= w_grant ? bus.req1_b : bus.req0_b;
            r_id <= w_grant;
         end
         if (r_state == ADD) begin
            r_rsp_sum   <= w_sum;
            r_rsp_cout  <= w_c[16];
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
         end
         if (r_state == RESP && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_last      <= r_rsp_id;
         end
      end
   end
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_id    = r_rsp_id;
   assign bus.rsp_sum   = r_rsp_sum;
   assign bus.rsp_cout  = r_rsp_cout;
   assign bus.busy      = r_state != IDLE;
endmodule

// File: tb/tb_adder16_arbiter.sv
// tb_adder16_arbiter: scoreboard bench for round-robin and fixed-priority arbiter instances
module tb_adder16_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   logic [17:0] q_rr[$];
   logic [17:0] q_fp[$];

   adder16_arbiter_if rr();
   adder16_arbiter_if fp();

   adder16_arbiter #(.PRIO_FIXED(1'b0)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(rr.slave));
   adder16_arbiter #(.PRIO_FIXED(1'b1)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(fp.slave));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // monitors: pop expected {id,cout,sum} at every completed response
   always @(negedge clk) begin
      if (rst_n && rr.rsp_valid && rr.rsp_ready) begin
         if (q_rr.size() == 0) chk("rr_unexpected_rsp", {rr.rsp_id, rr.rsp_cout, rr.rsp_sum}, 32'hdead);
         else chk("rr_rsp", {rr.rsp_id, rr.rsp_cout, rr.rsp_sum}, q_rr.pop_front());
      end
      if (rst_n && fp.rsp_valid && fp.rsp_ready) begin
         if (q_fp.size() == 0) chk("fp_unexpected_rsp", {fp.rsp_id, fp.rsp_cout, fp.rsp_sum}, 32'hdead);
         else chk("fp_rsp", {fp.rsp_id, fp.rsp_cout, fp.rsp_sum}, q_fp.pop_front());
      end
   end

   task automatic drain(input bit sel_fp, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         if ((sel_fp ? q_fp.size() : q_rr.size()) == 0) break;
         if (sel_fp && fp.req0_valid) chk("fp_req1_ready_blocked", fp.req1_ready, 1'b0);
         tick();
      end
      if (k == budget) chk("drain_timeout", k, 0);
   endtask

   task automatic op(input bit r, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] s, input logic c);
      q_rr.push_back({r, c, s});
      if (r) begin rr.req1_valid = 1'b1; rr.req1_a = a; rr.req1_b = b; end
      else   begin rr.req0_valid = 1'b1; rr.req0_a = a; rr.req0_b = b; end
      drain(1'b0, 20);
      rr.req0_valid = 1'b0;
      rr.req1_valid = 1'b0;
   endtask

   initial begin
      int k;
      {rr.req0_valid, rr.req1_valid, fp.req0_valid, fp.req1_valid} = '0;
      {rr.req0_a, rr.req0_b, rr.req1_a, rr.req1_b} = '0;
      {fp.req0_a, fp.req0_b, fp.req1_a, fp.req1_b} = '0;
      rr.rsp_ready = 1'b1;
      fp.rsp_ready = 1'b1;
      #1;
      chk("reset_outputs", {rr.rsp_valid, rr.rsp_id, rr.rsp_cout, rr.rsp_sum, rr.busy, rr.req0_ready, rr.req1_ready}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      // basic add with latency checks
      q_rr.push_back({1'b0, 1'b0, 16'h2345});
      rr.req0_valid = 1'b1; rr.req0_a = 16'h1234; rr.req0_b = 16'h1111;
      @(negedge clk);
      chk("req0_ready_pulse", rr.req0_ready, 1'b1);
      tick();
      rr.req0_valid = 1'b0;
      @(negedge clk);
      chk("add_state", {rr.rsp_valid, rr.busy, rr.req0_ready}, 3'b010);
      tick();
      @(negedge clk);
      chk("rsp_latency", rr.rsp_valid, 1'b1);
      tick();
      tick();
      chk("idle_after", rr.busy, 1'b0);
      // overflow
      op(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
      op(1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b1);
      op(1'b0, 16'hF00F, 16'h1FF1, 16'h1000, 1'b1);
      // round-robin: last grant was 0, so requester 1 wins the first tie
      q_rr.push_back({1'b1, 1'b0, 16'h0004});
      q_rr.push_back({1'b0, 1'b0, 16'h0002});
      q_rr.push_back({1'b1, 1'b0, 16'h0004});
      q_rr.push_back({1'b0, 1'b0, 16'h0002});
      rr.req0_a = 16'd1; rr.req0_b = 16'd1; rr.req1_a = 16'd2; rr.req1_b = 16'd2;
      rr.req0_valid = 1'b1; rr.req1_valid = 1'b1;
      drain(1'b0, 30);
      rr.req0_valid = 1'b0; rr.req1_valid = 1'b0;
      // fixed priority
      q_fp.push_back({1'b0, 1'b0, 16'h0002});
      q_fp.push_back({1'b0, 1'b0, 16'h0002});
      q_fp.push_back({1'b0, 1'b0, 16'h0002});
      fp.req0_a = 16'd1; fp.req0_b = 16'd1; fp.req1_a = 16'd2; fp.req1_b = 16'd2;
      fp.req0_valid = 1'b1; fp.req1_valid = 1'b1;
      drain(1'b1, 30);
      fp.req0_valid = 1'b0;
      q_fp.push_back({1'b1, 1'b0, 16'h0004});
      drain(1'b1, 20);
      fp.req1_valid = 1'b0;
      // backpressure
      rr.rsp_ready = 1'b0;
      q_rr.push_back({1'b0, 1'b0, 16'h0100});
      q_rr.push_back({1'b1, 1'b0, 16'h0007});
      rr.req0_valid = 1'b1; rr.req0_a = 16'h00FF; rr.req0_b = 16'h0001;
      for (k = 0; k < 10 && !rr.rsp_valid; k++) tick();
      if (k == 10) chk("bp_wait_timeout", k, 0);
      rr.req0_valid = 1'b0;
      rr.req1_valid = 1'b1; rr.req1_a = 16'h0003; rr.req1_b = 16'h0004;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         chk("bp_hold", {rr.rsp_valid, rr.rsp_id, rr.rsp_sum, rr.req0_ready, rr.req1_ready, rr.busy},
             {1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1});
         tick();
      end
      rr.rsp_ready = 1'b1;
      drain(1'b0, 20);
      rr.req1_valid = 1'b0;
      // async reset during ADD
      rr.req0_valid = 1'b1; rr.req0_a = 16'h0005; rr.req0_b = 16'h0006;
      tick();
      rr.req0_valid = 1'b0;
      @(negedge clk);
      chk("in_add", rr.busy, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset", {rr.rsp_valid, rr.rsp_id, rr.rsp_cout, rr.rsp_sum, rr.busy, rr.req0_ready, rr.req1_ready}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      q_rr.push_back({1'b0, 1'b0, 16'h1234});
      q_rr.push_back({1'b1, 1'b0, 16'h1010});
      rr.req0_a = 16'h1000; rr.req0_b = 16'h0234; rr.req1_a = 16'h0F0F; rr.req1_b = 16'h0101;
      rr.req0_valid = 1'b1; rr.req1_valid = 1'b1;
      drain(1'b0, 20);
      rr.req0_valid = 1'b0; rr.req1_valid = 1'b0;
      tick();
      chk("rr_queue_empty", q_rr.size(), 0);
      chk("fp_queue_empty", q_fp.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
